// File: rtl/vga_pkg.sv
// Shared definitions for the VGA sync decoder: default widths, lock FSM states
// and 640x480 reference timing totals.
package vga_pkg;

  localparam int HBITS_DEF = 10;
  localparam int VBITS_DEF = 10;

  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    MEAS   = 2'd1,
    VERIFY = 2'd2,
    LOCKED = 2'd3
  } sync_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an active-low sync input followed by a registered
// one-cycle pulse on each falling edge; everything idles high out of reset.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic fall_pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   pulse_q, pulse_d;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], sync_in};
    prev_d  = sync_q[SYNC_STAGES-1];
    pulse_d = prev_q & ~sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '1;
      prev_q  <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign fall_pulse = pulse_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers h/v position from incoming sync pins, measures line and frame length,
// and declares lock once two consecutive frames agree with the captured reference.
module vga_sync_decoder
  import vga_pkg::*;
#(
  parameter int HBITS       = HBITS_DEF,
  parameter int VBITS       = VBITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hSyncIn,
  input  logic             vSyncIn,
  output logic [HBITS-1:0] hCount,
  output logic [VBITS-1:0] vCount,
  output logic             hStart,
  output logic             vStart,
  output logic [HBITS-1:0] lineLen,
  output logic [VBITS-1:0] frameLines,
  output logic             locked
);

  localparam logic [HBITS-1:0] H_MAX = '1;
  localparam logic [HBITS-1:0] H_ONE = HBITS'(1);
  localparam logic [VBITS-1:0] V_MAX = '1;
  localparam logic [VBITS-1:0] V_ONE = VBITS'(1);

  logic h_start, v_start;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_h_edge (
    .clk       (clk),
    .rst       (rst),
    .sync_in   (hSyncIn),
    .fall_pulse(h_start)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_v_edge (
    .clk       (clk),
    .rst       (rst),
    .sync_in   (vSyncIn),
    .fall_pulse(v_start)
  );

  logic [HBITS-1:0] hcount_q, hcount_d, line_len_q, line_len_d, ref_line_q, ref_line_d;
  logic [VBITS-1:0] vcount_q, vcount_d, frame_lines_q, frame_lines_d, ref_frame_q, ref_frame_d;
  logic             hovf_q, hovf_d, locked_q, locked_d;
  logic [1:0]       meas_cnt_q, meas_cnt_d;
  sync_state_e      state_q, state_d;

  logic             h_max, v_max, ovf, line_bad, frame_bad;
  logic [HBITS-1:0] line_meas;
  logic [VBITS-1:0] vcount_inc, frame_meas;

  always_comb begin
    h_max      = (hcount_q == H_MAX);
    v_max      = (vcount_q == V_MAX);
    line_meas  = h_max ? H_MAX : hcount_q + H_ONE;
    vcount_inc = v_max ? V_MAX : vcount_q + V_ONE;
    // A line that starts together with the frame belongs to the old frame's count
    frame_meas = h_start ? vcount_inc : vcount_q;

    hcount_d      = h_start ? '0 : (h_max ? hcount_q : hcount_q + H_ONE);
    hovf_d        = h_start ? 1'b0 : (hovf_q | h_max);
    line_len_d    = h_start ? line_meas : line_len_q;
    vcount_d      = v_start ? '0 : (h_start ? vcount_inc : vcount_q);
    frame_lines_d = v_start ? frame_meas : frame_lines_q;
  end

  always_comb begin
    state_d     = state_q;
    ref_line_d  = ref_line_q;
    ref_frame_d = ref_frame_q;
    meas_cnt_d  = meas_cnt_q;
    // The hStart that ends an overflowed line also clears the flag, so it does not count
    ovf         = hovf_q & ~h_start;
    line_bad    = h_start && (line_meas != ref_line_q);
    frame_bad   = v_start && (frame_meas != ref_frame_q);

    case (state_q)
      SEARCH: begin
        if (v_start) begin
          state_d    = MEAS;
          meas_cnt_d = '0;
        end
      end
      MEAS: begin
        if (v_start) begin
          if (meas_cnt_q == 2'd2) begin
            state_d     = VERIFY;
            ref_frame_d = frame_meas;
          end else begin
            meas_cnt_d = '0;
          end
        end else if (h_start && (meas_cnt_q != 2'd2)) begin
          meas_cnt_d = meas_cnt_q + 2'd1;
          if (meas_cnt_q == 2'd1) ref_line_d = line_meas;
        end
      end
      VERIFY: begin
        if (line_bad || frame_bad) begin
          state_d     = MEAS;
          meas_cnt_d  = '0;
          ref_line_d  = '0;
          ref_frame_d = '0;
        end else if (v_start) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (line_bad || frame_bad) state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase

    if (ovf) state_d = SEARCH;
    if (state_d == SEARCH) begin
      ref_line_d  = '0;
      ref_frame_d = '0;
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      hovf_q        <= 1'b0;
      state_q       <= SEARCH;
      ref_line_q    <= '0;
      ref_frame_q   <= '0;
      meas_cnt_q    <= '0;
      locked_q      <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      hovf_q        <= hovf_d;
      state_q       <= state_d;
      ref_line_q    <= ref_line_d;
      ref_frame_q   <= ref_frame_d;
      meas_cnt_q    <= meas_cnt_d;
      locked_q      <= locked_d;
    end
  end

  assign hCount     = hcount_q;
  assign vCount     = vcount_q;
  assign hStart     = h_start;
  assign vStart     = v_start;
  assign lineLen    = line_len_q;
  assign frameLines = frame_lines_q;
  assign locked     = locked_q;

endmodule
